// File: rtl/load_ext_unit_if.sv
// Bus bundle for load_ext_unit: load issue, bus response, flush and writeback signals.
// The master side issues loads and returns bus data; the slave side is the load unit.
interface load_ext_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_loadop;
    logic [1:0]  req_addr_lo;
    logic [4:0]  req_wreg;
    logic [31:0] req_rt;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_wreg;
    logic [3:0]  pending;
    logic        err_unexpected;

    modport master (
        output req_valid, req_loadop, req_addr_lo, req_wreg, req_rt,
               flush, resp_valid, resp_rdata,
        input  req_ready, wb_valid, wb_data, wb_wreg, pending, err_unexpected
    );

    modport slave (
        input  req_valid, req_loadop, req_addr_lo, req_wreg, req_rt,
               flush, resp_valid, resp_rdata,
        output req_ready, wb_valid, wb_data, wb_wreg, pending, err_unexpected
    );
endinterface

// File: rtl/load_ext_unit.sv
// In-order tracker for outstanding data-bus loads: matches each response to its request,
// applies byte/half extension or LWL/LWR merging, and registers the writeback.
module load_ext_unit #(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    load_ext_unit_if.slave  bus
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LB  = 3'b001,
        OP_LBU = 3'b010,
        OP_LH  = 3'b011,
        OP_LHU = 3'b100,
        OP_LWL = 3'b101,
        OP_LWR = 3'b110,
        OP_RSV = 3'b111
    } loadop_e;

    typedef struct packed {
        logic [2:0]  loadop;
        logic [1:0]  addr_lo;
        logic [4:0]  wreg;
        logic [31:0] rt;
    } entry_t;

    entry_t             entries_q [DEPTH];
    logic [DEPTH-1:0]   killed_q, killed_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [3:0]         count_q, count_d;
    logic               wb_valid_q, wb_valid_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic [4:0]         wb_wreg_q, wb_wreg_d;
    logic               err_q, err_d;

    logic   push, pop;
    entry_t head;

    // Distance of slot idx from the read pointer, wrapping modulo DEPTH.
    function automatic logic [PTR_W-1:0] slot_offset(input int idx, input logic [PTR_W-1:0] rd);
        return PTR_W'(idx) - rd;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] rt, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (loadop_e'(op))
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'd0, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'd0, h};
            OP_LWL: begin
                case (a)
                    2'd0:    res = {rd[7:0],  rt[23:0]};
                    2'd1:    res = {rd[15:0], rt[15:0]};
                    2'd2:    res = {rd[23:0], rt[7:0]};
                    default: res = rd;
                endcase
            end
            OP_LWR: begin
                case (a)
                    2'd0:    res = rd;
                    2'd1:    res = {rt[31:24], rd[31:8]};
                    2'd2:    res = {rt[31:16], rd[31:16]};
                    default: res = {rt[31:8],  rd[31:24]};
                endcase
            end
            default: res = rd; // LW and the reserved encoding
        endcase
        return res;
    endfunction

    // The ready term deliberately ignores a same-cycle pop to keep it off the response path.
    assign bus.req_ready = (count_q < DEPTH_C) && !bus.flush;
    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = bus.resp_valid && (count_q != 4'd0);
    assign head          = entries_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        killed_d   = killed_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_wreg_d  = wb_wreg_q;
        err_d      = err_q | (bus.resp_valid && (count_q == 4'd0));

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase

        for (int i = 0; i < DEPTH; i++) begin
            if (bus.flush && (4'(slot_offset(i, rd_ptr_q)) < count_q)) killed_d[i] = 1'b1;
            if (push && (wr_ptr_q == PTR_W'(i)))                       killed_d[i] = 1'b0;
        end

        // A flush in the popping cycle kills that entry's writeback as well.
        if (pop && !killed_q[rd_ptr_q] && !bus.flush) begin
            wb_valid_d = 1'b1;
            wb_data_d  = extend(head.loadop, head.addr_lo, head.rt, bus.resp_rdata);
            wb_wreg_d  = head.wreg;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= 4'd0;
            killed_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_wreg_q  <= 5'd0;
            err_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            killed_q   <= killed_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_wreg_q  <= wb_wreg_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the entry payload is left unreset; an entry is only read after it has been
    // written, and the occupancy count already guards against stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[wr_ptr_q] <= '{loadop:  bus.req_loadop,
                                     addr_lo: bus.req_addr_lo,
                                     wreg:    bus.req_wreg,
                                     rt:      bus.req_rt};
        end
    end

    assign bus.wb_valid       = wb_valid_q;
    assign bus.wb_data        = wb_data_q;
    assign bus.wb_wreg        = wb_wreg_q;
    assign bus.pending        = count_q;
    assign bus.err_unexpected = err_q;

endmodule

// File: tb/tb_load_ext_unit.sv
// Directed bench for load_ext_unit: a table of single loads plus hand-written
// back-pressure, flush, unexpected-response and reset sequences.
module tb_load_ext_unit;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    load_ext_unit_if bus ();

    load_ext_unit #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [1:0]  a;
        logic [4:0]  wreg;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid   = 1'b0;
        bus.req_loadop  = 3'd0;
        bus.req_addr_lo = 2'd0;
        bus.req_wreg    = 5'd0;
        bus.req_rt      = 32'd0;
        bus.flush       = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_rdata  = 32'd0;
    endtask

    task automatic push(input logic [2:0] op, input logic [1:0] a, input logic [4:0] wreg,
                        input logic [31:0] rt);
        bus.req_valid   = 1'b1;
        bus.req_loadop  = op;
        bus.req_addr_lo = a;
        bus.req_wreg    = wreg;
        bus.req_rt      = rt;
        step();
        bus.req_valid   = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata);
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata;
        step();
        bus.resp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{"lb_a2",   3'b001, 2'd2, 5'd5,  32'h0,         32'h1280_3456, 32'hFFFF_FF80});
        vecs.push_back('{"lbu_a2",  3'b010, 2'd2, 5'd5,  32'h0,         32'h1280_3456, 32'h0000_0080});
        vecs.push_back('{"lwl_a1",  3'b101, 2'd1, 5'd10, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD});
        vecs.push_back('{"lwr_a2",  3'b110, 2'd2, 5'd11, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122});
        vecs.push_back('{"lw",      3'b000, 2'd0, 5'd31, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF});
        vecs.push_back('{"lh_a0",   3'b011, 2'd0, 5'd1,  32'h0,         32'h1234_8765, 32'hFFFF_8765});
        vecs.push_back('{"lhu_a2",  3'b100, 2'd2, 5'd2,  32'h0,         32'h8765_1234, 32'h0000_8765});
        vecs.push_back('{"lh_a1",   3'b011, 2'd1, 5'd3,  32'h0,         32'h1122_3344, 32'h0000_3344});
        vecs.push_back('{"lh_a3",   3'b011, 2'd3, 5'd4,  32'h0,         32'h8001_0000, 32'hFFFF_8001});
        vecs.push_back('{"lb_a3",   3'b001, 2'd3, 5'd6,  32'h0,         32'h7F00_0000, 32'h0000_007F});
        vecs.push_back('{"lb_a0",   3'b001, 2'd0, 5'd7,  32'h0,         32'h0000_00FF, 32'hFFFF_FFFF});
        vecs.push_back('{"lbu_a1",  3'b010, 2'd1, 5'd8,  32'h0,         32'h0000_AB00, 32'h0000_00AB});
        vecs.push_back('{"lwl_a0",  3'b101, 2'd0, 5'd12, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD});
        vecs.push_back('{"lwl_a2",  3'b101, 2'd2, 5'd13, 32'hAABB_CCDD, 32'h1122_3344, 32'h2233_44DD});
        vecs.push_back('{"lwl_a3",  3'b101, 2'd3, 5'd14, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344});
        vecs.push_back('{"lwr_a0",  3'b110, 2'd0, 5'd15, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344});
        vecs.push_back('{"lwr_a1",  3'b110, 2'd1, 5'd16, 32'hAABB_CCDD, 32'h1122_3344, 32'hAA11_2233});
        vecs.push_back('{"lwr_a3",  3'b110, 2'd3, 5'd17, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11});
        vecs.push_back('{"rsv_a1",  3'b111, 2'd1, 5'd18, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344});

        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_pending",   32'(bus.pending),        32'd0);
        check("rst_wb_valid",  32'(bus.wb_valid),       32'd0);
        check("rst_wb_data",   bus.wb_data,             32'd0);
        check("rst_wb_wreg",   32'(bus.wb_wreg),        32'd0);
        check("rst_err",       32'(bus.err_unexpected), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready),      32'd1);

        // Single loads; consecutive entries also walk the pointers around the FIFO.
        foreach (vecs[i]) begin
            push(vecs[i].op, vecs[i].a, vecs[i].wreg, vecs[i].rt);
            check({vecs[i].name, "_pending"}, 32'(bus.pending), 32'd1);
            check({vecs[i].name, "_no_early_wb"}, 32'(bus.wb_valid), 32'd0);
            respond(vecs[i].rdata);
            check({vecs[i].name, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
            check({vecs[i].name, "_wb_data"},  bus.wb_data,        vecs[i].exp);
            check({vecs[i].name, "_wb_wreg"},  32'(bus.wb_wreg),   32'(vecs[i].wreg));
            step();
            check({vecs[i].name, "_wb_drop"},  32'(bus.wb_valid), 32'd0);
        end

        // Full FIFO, back-pressure, then push and pop in one cycle.
        push(3'b011, 2'd2, 5'd1, 32'h0);
        push(3'b100, 2'd0, 5'd2, 32'h0);
        check("full_pending", 32'(bus.pending),   32'd2);
        check("full_ready",   32'(bus.req_ready), 32'd0);
        respond(32'h8001_7FFF);
        check("full_wb1_valid", 32'(bus.wb_valid), 32'd1);
        check("full_wb1_data",  bus.wb_data,       32'hFFFF_8001);
        check("full_wb1_wreg",  32'(bus.wb_wreg),  32'd1);
        check("full_pending1",  32'(bus.pending),  32'd1);
        bus.req_valid   = 1'b1;
        bus.req_loadop  = 3'b000;
        bus.req_addr_lo = 2'd0;
        bus.req_wreg    = 5'd3;
        bus.resp_valid  = 1'b1;
        bus.resp_rdata  = 32'h0000_FFFF;
        #1;
        check("pp_ready", 32'(bus.req_ready), 32'd1);
        step();
        idle_inputs();
        check("pp_wb2_valid", 32'(bus.wb_valid), 32'd1);
        check("pp_wb2_data",  bus.wb_data,       32'h0000_FFFF);
        check("pp_wb2_wreg",  32'(bus.wb_wreg),  32'd2);
        check("pp_pending",   32'(bus.pending),  32'd1);
        respond(32'hCAFE_F00D);
        check("pp_wb3_data", bus.wb_data,      32'hCAFE_F00D);
        check("pp_wb3_wreg", 32'(bus.wb_wreg), 32'd3);
        check("pp_drained",  32'(bus.pending), 32'd0);

        // Flush with two loads outstanding.
        push(3'b000, 2'd0, 5'd6, 32'h0);
        push(3'b000, 2'd0, 5'd7, 32'h0);
        bus.flush = 1'b1;
        #1;
        check("flush_ready", 32'(bus.req_ready), 32'd0);
        step();
        bus.flush = 1'b0;
        check("flush_pending", 32'(bus.pending), 32'd2);
        respond(32'h1111_1111);
        check("flush_k1_wb",      32'(bus.wb_valid), 32'd0);
        check("flush_k1_pending", 32'(bus.pending),  32'd1);
        respond(32'h2222_2222);
        check("flush_k2_wb",      32'(bus.wb_valid), 32'd0);
        check("flush_k2_pending", 32'(bus.pending),  32'd0);
        push(3'b000, 2'd0, 5'd8, 32'h0);
        respond(32'h1357_9BDF);
        check("post_flush_valid", 32'(bus.wb_valid), 32'd1);
        check("post_flush_data",  bus.wb_data,       32'h1357_9BDF);
        check("post_flush_wreg",  32'(bus.wb_wreg),  32'd8);

        // Flush in the same cycle as the popping response.
        push(3'b000, 2'd0, 5'd9, 32'h0);
        bus.flush = 1'b1;
        respond(32'h5555_AAAA);
        bus.flush = 1'b0;
        check("flush_pop_wb",      32'(bus.wb_valid), 32'd0);
        check("flush_pop_pending", 32'(bus.pending),  32'd0);
        check("no_err_yet",        32'(bus.err_unexpected), 32'd0);

        // Response with nothing outstanding.
        respond(32'h9999_9999);
        check("unexp_err",     32'(bus.err_unexpected), 32'd1);
        check("unexp_wb",      32'(bus.wb_valid),       32'd0);
        check("unexp_pending", 32'(bus.pending),        32'd0);
        step();
        step();
        check("unexp_sticky", 32'(bus.err_unexpected), 32'd1);

        // Reset with one load outstanding, then a stray response.
        push(3'b000, 2'd0, 5'd4, 32'h0);
        check("mid_pending", 32'(bus.pending), 32'd1);
        rst = 1'b1;
        bus.resp_valid = 1'b1;
        bus.resp_rdata = 32'h7777_7777;
        step();
        rst = 1'b0;
        bus.resp_valid = 1'b0;
        check("mid_rst_pending", 32'(bus.pending),        32'd0);
        check("mid_rst_wb",      32'(bus.wb_valid),       32'd0);
        check("mid_rst_err",     32'(bus.err_unexpected), 32'd0);
        respond(32'h8888_8888);
        check("after_rst_err", 32'(bus.err_unexpected), 32'd1);
        check("after_rst_wb",  32'(bus.wb_valid),       32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_ext_unit.md
LOAD_EXT_UNIT -- requirements
Module: load_ext_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, giving the maximum number of outstanding loads (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  a load is issued to the data bus this cycle.
REQ-005 SHALL have port req_ready  output  1  a request can be accepted this cycle.
REQ-006 SHALL have port req_loadop  input  3  load type: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LWL, 110 LWR, 111 reserved.
REQ-007 SHALL have port req_addr_lo  input  2  byte address bits [1:0] of the load.
REQ-008 SHALL have port req_wreg  input  5  destination register number.
REQ-009 SHALL have port req_rt  input  32  old rt value, used by LWL/LWR merging.
REQ-010 SHALL have port flush  input  1  kill all outstanding loads (exception/ERET).
REQ-011 SHALL have port resp_valid  input  1  the data bus returns read data this cycle.
REQ-012 SHALL have port resp_rdata  input  32  returned word (little-endian).
REQ-013 SHALL have port wb_valid  output  1  wb_data/wb_wreg are valid this cycle.
REQ-014 SHALL have port wb_data  output  32  extended/merged load result.
REQ-015 SHALL have port wb_wreg  output  5  destination register of wb_data.
REQ-016 SHALL have port pending  output  4  count of occupied entries (0..DEPTH).
REQ-017 SHALL have port err_unexpected  output  1  sticky flag: a response arrived with no entry.

Function
REQ-018 SHALL store each accepted request (req_valid && req_ready) in an in-order FIFO entry holding loadop, addr_lo, wreg, rt and a killed bit (cleared on push).
REQ-019 SHALL drive req_ready = (pending < DEPTH) && !flush. Req_ready SHALL NOT count a same-cycle pop.
REQ-020 SHALL pop the oldest entry when resp_valid=1 and pending>0. Responses SHALL be matched strictly in issue order.
REQ-021 SHALL support push and pop in the same cycle with pending unchanged. A response never matches a request pushed in the same cycle.
REQ-022 SHALL handle resp_valid=1 with pending=0 as follows: ignore it, set err_unexpected=1 (held until rst), and leave wb_valid=0.
REQ-023 SHALL register the result. wb_valid/wb_data/wb_wreg SHALL appear exactly one cycle after the popping resp_valid. wb_valid SHALL be 0 in every other cycle.
REQ-024 SHALL, with b = byte addr_lo of resp_rdata and h = addr_lo[1] ? rdata[31:16] : rdata[15:0], compute wb_data per loadop:
- LW: rdata.
- LB: sign-extend b.
- LBU: zero-extend b.
- LH: sign-extend h.
- LHU: zero-extend h.
REQ-025 SHALL compute LWL by addr_lo: 0 {rdata[7:0],rt[23:0]}; 1 {rdata[15:0],rt[15:0]}; 2 {rdata[23:0],rt[7:0]}; 3 rdata.
REQ-026 SHALL compute LWR by addr_lo: 0 rdata; 1 {rt[31:24],rdata[31:8]}; 2 {rt[31:16],rdata[31:16]}; 3 {rt[31:8],rdata[31:24]}.
REQ-027 SHALL treat reserved loadop 111 as LW. Misalignment is checked upstream; LH/LHU use only addr_lo[1].
REQ-028 SHALL, on flush=1, set the killed bit of every entry occupied at that edge, including one popped in that cycle. A killed entry still pops on its response but produces wb_valid=0 (its data is discarded).
REQ-029 SHALL keep pointers and pending unaffected by flush. Bus responses to killed loads are still consumed, so no response is mismatched.
REQ-030 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-031 SHALL, when rst=1 at a rising edge, set the following, with rst priority over every other input including a simultaneous req, resp or flush:
- pointers 0, pending 0, all killed bits 0.
- wb_valid 0, wb_data 0, wb_wreg 0, err_unexpected 0.
REQ-032 SHALL drop all outstanding entries on reset mid-operation. The first response after reset with pending=0 obeys REQ-022.

Verification
REQ-033 SHALL pass these single loads, each producing wb_valid one cycle after the response:
- LB, addr_lo=2, wreg=5, rdata=0x1280_3456 -> wb_data=0xFFFF_FF80, wb_wreg=5.
- LBU, same inputs -> wb_data=0x0000_0080.
REQ-034 SHALL pass these merges with rt=0xAABB_CCDD, rdata=0x1122_3344:
- LWL, addr_lo=1 -> 0x3344_CCDD.
- LWR, addr_lo=2 -> 0xAABB_1122.
REQ-035 SHALL pass a full/back-pressure case with DEPTH=2:
- Push LH addr_lo=2 then LHU addr_lo=0 -> pending=2, req_ready=0.
- Response 0x8001_7FFF, next cycle push plus response 0x0000_FFFF -> wb 0xFFFF_8001, then 0x0000_FFFF, in order.
REQ-036 SHALL pass a flush case:
- Two loads pending, flush=1 -> req_ready=0 that cycle.
- Both later responses pop with wb_valid=0.
- A new LW issued after flush returns its own rdata with wb_valid=1.
REQ-037 SHALL pass an unexpected-response case: resp_valid with pending=0 -> err_unexpected=1, stays 1 until rst, and no wb_valid.
REQ-038 SHALL pass a reset mid-operation case: one load pending, rst=1 -> pending=0, wb_valid=0 and the subsequent response sets err_unexpected.
